// File: rtl/register_file_param.sv
// Parametrised register file: one write port, two combinational read ports,
// sequenced bulk-clear engine and sticky write-drop flag. Optional REGFILE_BYPASS_EN adds write-to-read forwarding.
module register_file_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              clr,
    output logic              busy,
    output logic              wr_err,
    input  logic              err_ack
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic wr_ok;
    logic wr_drop;

    // A write lands only when idle and not colliding with a clear request.
    assign wr_ok   = we && (state_q == ST_IDLE) && !clr;
    assign wr_drop = we && !wr_ok;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;

        if (state_q == ST_IDLE) begin
            if (clr) begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        end else begin
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end

        if (wr_drop) begin
            err_d = 1'b1;
        end else if (err_ack) begin
            err_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array itself is reset because reset must zero every entry immediately; this rules out a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            mem_q[idx_q] <= '0;
        end else if (wr_ok) begin
            mem_q[wa] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
        if (wr_ok && (wa == ra1)) rd1 = wd;
        if (wr_ok && (wa == ra2)) rd2 = wd;
    end
`else
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
    end
`endif

    assign busy   = (state_q == ST_CLEAR);
    assign wr_err = err_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed self-checking bench for register_file_param (16x16 default and a 32x8 instance).
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        we = 1'b0, clr = 1'b0, err_ack = 1'b0;
    logic [3:0]  wa = '0, ra1 = '0, ra2 = '0;
    logic [15:0] wd = '0;
    logic [15:0] rd1, rd2;
    logic        busy, wr_err;

    logic        p_we = 1'b0, p_clr = 1'b0, p_err_ack = 1'b0;
    logic [2:0]  p_wa = '0, p_ra1 = '0, p_ra2 = '0;
    logic [31:0] p_wd = '0;
    logic [31:0] p_rd1, p_rd2;
    logic        p_busy, p_wr_err;

    int tests = 0;
    int fails = 0;

    register_file_param dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .clr(clr), .busy(busy), .wr_err(wr_err), .err_ack(err_ack)
    );

    register_file_param #(.WIDTH(32), .DEPTH(8)) dut_p (
        .clk(clk), .rst(rst), .we(p_we), .wa(p_wa), .wd(p_wd),
        .ra1(p_ra1), .ra2(p_ra2), .rd1(p_rd1), .rd2(p_rd2),
        .clr(p_clr), .busy(p_busy), .wr_err(p_wr_err), .err_ack(p_err_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    int cnt;

    initial begin
        // Power-on reset state.
        #2;
        check("por_busy", 64'(busy), 64'd0);
        check("por_err", 64'(wr_err), 64'd0);
        check("por_rd1", 64'(rd1), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Preload, then start a sweep with a colliding write, then reset mid-clock.
        write(4'd3, 16'h1111);
        write(4'd15, 16'h2222);
        ra1 = 4'd3; ra2 = 4'd15;
        clr = 1'b1; we = 1'b1; wa = 4'd3; wd = 16'h9999;
        tick();
        clr = 1'b0; we = 1'b0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_err", 64'(wr_err), 64'd1);
        check("clr_we_dropped", 64'(rd1), 64'h1111);
        #2 rst = 1'b1;
        #1;
        check("rst_rd1", 64'(rd1), 64'd0);
        check("rst_rd2", 64'(rd2), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(wr_err), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Write / read, including both ports on one entry.
        write(4'd3, 16'hBEEF);
        write(4'd15, 16'h1234);
        ra1 = 4'd3; ra2 = 4'd15;
        #1;
        check("rd1_e3", 64'(rd1), 64'hBEEF);
        check("rd2_e15", 64'(rd2), 64'h1234);
        ra2 = 4'd3;
        #1;
        check("same_rd1", 64'(rd1), 64'hBEEF);
        check("same_rd2", 64'(rd2), 64'hBEEF);

        // Forwarding: same-cycle value depends on the build option.
        write(4'd5, 16'h1111);
        ra1 = 4'd5;
        we = 1'b1; wa = 4'd5; wd = 16'h00FF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", 64'(rd1), 64'h00FF);
`else
        check("nobypass_same_cycle", 64'(rd1), 64'h1111);
`endif
        tick();
        we = 1'b0;
        check("after_write_e5", 64'(rd1), 64'h00FF);

        // Fill and sweep; second clr and a dropped write at cycle 5.
        for (int i = 0; i < 16; i++) write(4'(i), 16'hA5A5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ra1 = 4'(k);
            #1;
            check($sformatf("sweep_busy_%0d", k), 64'(busy), 64'd1);
            check($sformatf("sweep_old_%0d", k), 64'(rd1), 64'hA5A5);
            if (k == 4) begin
                clr = 1'b1; we = 1'b1; wa = 4'd2; wd = 16'h7777;
            end
            if (k == 5) check("sweep_drop_err", 64'(wr_err), 64'd1);
            tick();
            clr = 1'b0; we = 1'b0;
            check($sformatf("sweep_cleared_%0d", k), 64'(rd1), 64'd0);
        end
        check("sweep_done_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 16; i++) begin
            ra2 = 4'(i);
            #1;
            check($sformatf("all_zero_%0d", i), 64'(rd2), 64'd0);
        end
        check("err_holds", 64'(wr_err), 64'd1);
        err_ack = 1'b1;
        tick();
        err_ack = 1'b0;
        check("err_ack_clears", 64'(wr_err), 64'd0);

        // clr+we in IDLE: clr wins; then ack racing a new drop.
        write(4'd9, 16'h4444);
        ra1 = 4'd9;
        clr = 1'b1; we = 1'b1; wa = 4'd9; wd = 16'h7777;
        tick();
        clr = 1'b0; we = 1'b0;
        check("idle_coll_busy", 64'(busy), 64'd1);
        check("idle_coll_err", 64'(wr_err), 64'd1);
        check("idle_coll_nowrite", 64'(rd1), 64'h4444);
        err_ack = 1'b1; we = 1'b1; wa = 4'd12; wd = 16'h5555;
        tick();
        err_ack = 1'b0; we = 1'b0;
        check("set_beats_ack", 64'(wr_err), 64'd1);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check("sweep2_ends", 64'(busy), 64'd0);
        ra2 = 4'd12;
        #1;
        check("dropped_e12", 64'(rd2), 64'd0);
        check("e9_cleared", 64'(rd1), 64'd0);

        // 32x8 instance.
        p_we = 1'b1; p_wa = 3'd7; p_wd = 32'hDEADBEEF;
        tick();
        p_we = 1'b0;
        p_ra1 = 3'd7;
        #1;
        check("p_rd1_e7", 64'(p_rd1), 64'hDEADBEEF);
        p_clr = 1'b1;
        tick();
        p_clr = 1'b0;
        cnt = 0;
        while (p_busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check("p_busy_cycles", 64'(cnt), 64'd8);
        check("p_e7_cleared", 64'(p_rd1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
